// File: rtl/cook_timer_pkg.sv
// cook_timer shared types and constants.
// State encoding and BCD wrap values.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/cook_timer_bcd_digit_dec.sv
// One BCD display digit: clear, shift-load,
// decrement with borrow and configurable wrap.
module bcd_digit_dec
  import cook_timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow
);

  assign borrow = dec && (q == 4'd0);

  // Clear wins, then decrement, then shift-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (dec) begin
      q <= borrow ? WRAP : q - 4'd1;
    end else if (load) begin
      q <= load_val;
    end
  end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook countdown timer (mm:ss BCD).
// FSM, prescaler and keypad shift control.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int PW       = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       mag,
  output logic       timerDone,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running
);

  state_t          state;
  logic [PW-1:0]   presc;
  logic [3:0]      bw;
  logic            clr;
  logic            accept;
  logic            time_nz;
  logic            shift_nz;
  logic            counting;
  logic            wrap;
  logic            tick;
  logic            last_sec;

  assign clr      = !clearn;
  assign accept   = clearn && !mag && digit_valid
                 && (digit <= BCD_MAX_ONES);
  assign time_nz  = |{min_tens, min_ones,
                      sec_tens, sec_ones};
  assign shift_nz = |{min_ones, sec_tens,
                      sec_ones, digit};
  assign counting = mag && time_nz
                 && (state != DONE);
  assign wrap     = (presc == PW'(TICK_DIV - 1));
  assign tick     = clearn && counting && wrap;
  assign last_sec = ({min_tens, min_ones,
                      sec_tens} == 12'd0)
                 && (sec_ones == 4'd1);

  bcd_digit_dec #(.WRAP(BCD_MAX_ONES)) u_so (
    .clk(clk), .rst_n(resetn), .clr(clr),
    .load(accept), .load_val(digit),
    .dec(tick), .q(sec_ones), .borrow(bw[0])
  );

  bcd_digit_dec #(.WRAP(BCD_MAX_SEC_TENS)) u_st (
    .clk(clk), .rst_n(resetn), .clr(clr),
    .load(accept), .load_val(sec_ones),
    .dec(bw[0]), .q(sec_tens), .borrow(bw[1])
  );

  bcd_digit_dec #(.WRAP(BCD_MAX_ONES)) u_mo (
    .clk(clk), .rst_n(resetn), .clr(clr),
    .load(accept), .load_val(sec_tens),
    .dec(bw[1]), .q(min_ones), .borrow(bw[2])
  );

  bcd_digit_dec #(.WRAP(BCD_MAX_ONES)) u_mt (
    .clk(clk), .rst_n(resetn), .clr(clr),
    .load(accept), .load_val(min_ones),
    .dec(bw[2]), .q(min_tens), .borrow(bw[3])
  );

  // State, prescaler, done flag and running flag.
  // A borrow out of min_tens also ends the run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      presc     <= '0;
      timerDone <= 1'b0;
      running   <= 1'b0;
    end else if (!clearn) begin
      state     <= IDLE;
      presc     <= '0;
      timerDone <= 1'b0;
      running   <= 1'b0;
    end else if (mag) begin
      if (state == DONE) begin
        presc <= '0;
      end else if (!time_nz) begin
        state     <= DONE;
        presc     <= '0;
        timerDone <= 1'b1;
        running   <= 1'b0;
      end else if (tick && (last_sec || bw[3])) begin
        state     <= DONE;
        presc     <= '0;
        timerDone <= 1'b1;
        running   <= 1'b0;
      end else begin
        state   <= RUN;
        presc   <= wrap ? '0 : presc + 1'b1;
        running <= 1'b1;
      end
    end else if (accept) begin
      state     <= shift_nz ? SET : IDLE;
      timerDone <= 1'b0;
      running   <= 1'b0;
    end else if (state == RUN) begin
      state   <= SET;
      running <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer.
// Behavioural mm:ss model plus directed literals.
module tb_cook_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clearn = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       mag = 1'b0;
  logic       timerDone;
  logic       running;
  logic [3:0] min_tens, min_ones;
  logic [3:0] sec_tens, sec_ones;

  int checks = 0;
  int errors = 0;

  // model: minutes and seconds as plain integers
  int m_min = 0;
  int m_sec = 0;
  int m_pre = 0;
  bit m_done = 0;
  bit m_run = 0;
  bit m_fin = 0;

  cook_timer #(.TICK_DIV(TD), .PW(3)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn),
    .digit_valid(digit_valid), .digit(digit),
    .mag(mag), .timerDone(timerDone),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] dut_disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] mdl_disp();
    return {bcd(m_min), bcd(m_sec)};
  endfunction

  task automatic chk(input string n,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               n, got, exp, $time);
    end
  endtask

  // pin both DUT and model to a hand value
  task automatic lit(input string n,
                     input logic [15:0] exp);
    chk({n, "_dut"}, dut_disp(), exp);
    chk({n, "_mdl"}, mdl_disp(), exp);
  endtask

  // Behavioural reference, updated per clock edge.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_min = 0; m_sec = 0; m_pre = 0;
      m_done = 0; m_run = 0; m_fin = 0;
    end else if (!clearn) begin
      m_min = 0; m_sec = 0; m_pre = 0;
      m_done = 0; m_run = 0; m_fin = 0;
    end else if (mag) begin
      if (m_fin) begin
        m_pre = 0;
      end else if (m_min == 0 && m_sec == 0) begin
        m_done = 1; m_fin = 1; m_run = 0; m_pre = 0;
      end else begin
        m_run = 1;
        m_pre++;
        if (m_pre == TD) begin
          m_pre = 0;
          if (m_sec > 0) m_sec--;
          else begin
            m_sec = 59;
            m_min--;
          end
          if (m_min == 0 && m_sec == 0) begin
            m_done = 1; m_fin = 1; m_run = 0;
          end
        end
      end
    end else if (digit_valid && digit <= 4'd9) begin
      m_min = (m_min % 10) * 10 + m_sec / 10;
      m_sec = (m_sec % 10) * 10 + int'(digit);
      m_done = 0; m_fin = 0; m_run = 0;
    end else begin
      m_run = 0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("disp", dut_disp(), mdl_disp());
    chk("timerDone", 16'(timerDone), 16'(m_done));
    chk("running", 16'(running), 16'(m_run));
  end

  task automatic step(input logic m, input logic v,
                      input logic [3:0] d,
                      input logic c);
    mag = m; digit_valid = v; digit = d; clearn = c;
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b1, d, 1'b1);
  endtask

  task automatic run(input logic m, input int n);
    for (int i = 0; i < n; i++)
      step(m, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  logic       rm;
  logic       rv;
  logic [3:0] rd;
  logic       rc;

  initial begin
    @(negedge clk);
    @(negedge clk);
    lit("reset", 16'h0000);
    chk("reset_done", 16'(timerDone), 16'd0);
    chk("reset_run", 16'(running), 16'd0);
    resetn = 1'b1;

    key(4'd1); key(4'd3); key(4'd0);
    lit("enter_0130", 16'h0130);
    run(1'b1, TD);
    lit("first_tick", 16'h0129);
    chk("run_flag", 16'(running), 16'd1);
    run(1'b1, 29 * TD);
    lit("at_0100", 16'h0100);
    run(1'b1, TD);
    lit("borrow_0059", 16'h0059);

    clear();
    key(4'd0); key(4'd2);
    lit("enter_0002", 16'h0002);
    run(1'b1, 2 * TD - 1);
    lit("pre_done", 16'h0001);
    chk("pre_done_flag", 16'(timerDone), 16'd0);
    run(1'b1, 1);
    lit("done_0000", 16'h0000);
    chk("done_flag", 16'(timerDone), 16'd1);
    run(1'b0, 2);
    chk("done_held", 16'(timerDone), 16'd1);
    clear();
    chk("done_cleared", 16'(timerDone), 16'd0);

    key(4'd5);
    run(1'b1, 2);
    run(1'b0, 10);
    run(1'b1, 2);
    lit("pause_0004", 16'h0004);

    clear();
    run(1'b1, 1);
    chk("zero_start_done", 16'(timerDone), 16'd1);
    step(1'b1, 1'b1, 4'd7, 1'b1);
    lit("key_mag_ign", 16'h0000);
    step(1'b0, 1'b1, 4'd12, 1'b1);
    lit("key_12_ign", 16'h0000);
    chk("key_12_done", 16'(timerDone), 16'd1);
    key(4'd7);
    lit("key_7", 16'h0007);
    chk("key_7_done", 16'(timerDone), 16'd0);

    clear();
    key(4'd9); key(4'd0);
    lit("enter_0090", 16'h0090);
    run(1'b1, 2 * TD);
    lit("count_0088", 16'h0088);
    run(1'b0, 1);
    key(4'd1); key(4'd2); key(4'd3);
    key(4'd4); key(4'd5);
    lit("shift_2345", 16'h2345);

    clear();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    run(1'b1, TD);
    lit("max_9998", 16'h9998);

    clear();
    key(4'd1); key(4'd1); key(4'd0);
    run(1'b1, 3);
    #2 resetn = 1'b0;
    #1;
    chk("async_disp", dut_disp(), 16'h0000);
    chk("async_run", 16'(running), 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 1'b1, 4'd5, 1'b0);
    lit("clr_vs_key", 16'h0000);

    rm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) rm = ~rm;
      rv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0)
        rd = 4'(10 + $urandom_range(0, 5));
      else
        rd = 4'($urandom_range(0, 9));
      rc = ($urandom_range(0, 299) != 0);
      step(rm, rv, rd, rc);
      if (i == 1500) begin
        #3 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Countdown timer for the microwave controller. It generates the timerDone input that the magnetron control consumes, and it counts down only while that control's mag output is high.
- Cook time is entered as BCD keypad digits shifted in from the right (mm:ss). The block decrements once per second and asserts timerDone when the time reaches 00:00.
- Outputs drive the display digits directly.

Parameters:
- TICK_DIV, 1000: clk cycles per countdown second. The clk is 1 kHz; benches override it with a small value.
- PW, 10: prescaler counter width. Must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- clearn  in  1  synchronous active-low clear of time, prescaler and timerDone
- digit_valid  in  1  one-cycle strobe: digit is valid
- digit  in  4  BCD keypad digit
- mag  in  1  magnetron on; countdown enable
- timerDone  out  1  registered; high when a run reached 00:00
- min_tens  out  4  BCD display digit
- min_ones  out  4  BCD display digit
- sec_tens  out  4  BCD display digit
- sec_ones  out  4  BCD display digit
- running  out  1  high in RUN state

Behaviour:
- Reset (resetn=0, asynchronous):
  - all four digits = 0, prescaler = 0, timerDone = 0, running = 0.
  - State = IDLE.
- States:
  - IDLE: time = 0, mag = 0.
  - SET: time != 0, mag = 0.
  - RUN: mag = 1, time != 0.
  - DONE: time = 0, reached either by counting down in RUN or by mag = 1 with time = 0.
- Priority per clock edge: clearn > mag/countdown > digit entry.
- clearn = 0:
  - digits = 0, prescaler = 0, timerDone = 0; next state IDLE.
  - A simultaneous digit_valid is ignored.
- Digit entry is accepted only when mag = 0, digit_valid = 1 and digit <= 9.
  - Shift: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= digit. The old min_tens is discarded.
  - Any accepted digit clears timerDone.
  - Next state is SET if the resulting time != 0, else IDLE.
  - Digits 10–15 are ignored with no state change.
  - Digit entry while mag = 1 is ignored.
- Prescaler:
  - Increments each cycle while mag = 1 and state is RUN.
  - Holds its value while mag = 0, so a pause keeps the partial second.
  - When it equals TICK_DIV-1, it wraps to 0 and issues tick.
- Decrement on tick (BCD borrow chain):
  - sec_ones 0 -> 9 with a borrow into sec_tens.
  - sec_tens 0 -> 5 with a borrow into minutes.
  - min_ones 0 -> 9 with a borrow into min_tens.
  - Entered sec_tens values above 5 (e.g. 00:90) are legal and count down normally: 90 -> 89.
- Completion: on the tick that takes the time from 00:01 to 00:00, timerDone goes to 1 on the same edge and the state moves to DONE.
  - First-tick latency after entering RUN is TICK_DIV cycles, or the remainder left from a pause.
- mag = 1 with time = 00:00 (from IDLE): timerDone = 1 on the next edge; state DONE.
- DONE:
  - timerDone stays high regardless of mag.
  - It is cleared only by clearn or by an accepted digit (with mag = 0).
  - The prescaler is held at 0.
- RUN -> SET when mag falls with time != 0; timerDone stays 0.
- Upper bound: maximum entered time is 99:99, which counts 99:99 -> 99:98 ... with no overflow.
- Reset asserted mid-run forces the reset values immediately, with no tick.
- running = 1 exactly in RUN; it is registered alongside the state.

Decomposition:
- Shared package/header:
  - state encoding localparams: IDLE=2'd0, SET=2'd1, RUN=2'd2, DONE=2'd3;
  - BCD constants: BCD_MAX_ONES = 9, BCD_MAX_SEC_TENS = 5.
- Sub-module bcd_digit_dec: one 4-bit BCD digit with load/shift, decrement-on-borrow-in, borrow-out and a configurable wrap value (9 or 5).
  - Instanced four times: wrap 9, 5, 9, 9.
- cook_timer holds the FSM, the prescaler and the shift control.

Test Plan:
- Reset, then enter digits 1, 3, 0 with TICK_DIV = 4 -> display 01:30 and state SET; mag = 1 for 4 cycles -> 01:29; continue -> at 01:00 the next tick gives 00:59.
- Enter 0, 2; mag = 1 -> after 8 cycles time = 00:00 and timerDone = 1 on the same edge; timerDone stays 1 after mag = 0 until a clearn pulse -> 0.
- Enter 5; mag = 1 for 2 cycles, mag = 0 for 10 cycles, mag = 1 for 2 cycles -> 00:04 exactly at the end (partial second held across the pause).
- With 00:00 in IDLE, mag = 1 -> timerDone = 1 after 1 edge; digit 7 while mag = 1 -> ignored; digit 12 with mag = 0 -> ignored; digit 7 with mag = 0 -> 00:07 and timerDone = 0.
- Enter 9, 0 -> 00:90; run 2 ticks -> 00:88; enter 1, 2, 3, 4, 5 -> 23:45 (oldest digit dropped).
- Mid-run (01:10), pulse resetn low asynchronously between edges -> outputs 0 immediately; clearn = 0 together with digit_valid -> time stays 00:00.
